// File: rtl/combinational_circuit_core.sv
// combinational_circuit_core
// Leaf decoder for the three-bit input code {x,y,z}. Provides the three
// decode functions combinationally for same-cycle consumers, plus a
// registered copy with a valid strobe and a sticky coverage mask of all
// codes that have been accepted since reset.
module combinational_circuit_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  input  logic       g,
  input  logic       in_valid,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic       f1_q,
  output logic       f2_q,
  output logic       f3_q,
  output logic       out_valid,
  output logic [7:0] cov_mask,
  output logic       cov_full
);

  logic [2:0] code;
  logic       accept;
  logic [7:0] code_onehot;

  assign code   = {x, y, z};
  assign accept = in_valid & ~g;

  // Decode functions; each pair of terms is disjoint, so XOR acts as OR.
  always_comb begin
    f1 = (x & z) ^ (~x & ~y & ~z);
    f2 = (~x & y) ^ (x & ~y & ~z);
    f3 = (x & y) ^ (~x & ~y & ~z);
  end

  // One-hot of the current code, used to set the coverage bit.
  always_comb begin
    code_onehot       = 8'h00;
    code_onehot[code] = 1'b1;
  end

  // Registered copy of the decode, captured only on an accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
      f3_q <= 1'b0;
    end else if (accept) begin
      f1_q <= f1;
      f2_q <= f2;
      f3_q <= f3;
    end
  end

  // Valid strobe: high for exactly the cycle following each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
    end
  end

  // Sticky coverage of accepted codes; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_mask <= 8'h00;
    end else if (accept) begin
      cov_mask <= cov_mask | code_onehot;
    end
  end

  assign cov_full = (cov_mask == 8'hFF);

endmodule

// File: tb/tb_combinational_circuit_core.sv
module tb_combinational_circuit_core;

  logic       clk;
  logic       rst_n;
  logic       x, y, z, g, in_valid;
  logic       f1, f2, f3, f1_q, f2_q, f3_q, out_valid, cov_full;
  logic [7:0] cov_mask;

  int checks = 0;
  int errors = 0;

  // Reference truth table {f1,f2,f3} for codes 0..7.
  logic [2:0] tbl [8] = '{3'b101, 3'b000, 3'b010, 3'b010,
                          3'b010, 3'b100, 3'b001, 3'b101};

  typedef struct packed {
    logic [2:0] fq;
    logic [7:0] mask;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model_mask = 8'h00;
  exp_t       hold = '0;

  combinational_circuit_core dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z), .g(g),
    .in_valid(in_valid), .f1(f1), .f2(f2), .f3(f3),
    .f1_q(f1_q), .f2_q(f2_q), .f3_q(f3_q), .out_valid(out_valid),
    .cov_mask(cov_mask), .cov_full(cov_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: observe what the DUT sees at each rising edge.
  always @(posedge clk) begin
    if (rst_n && in_valid && !g) begin
      exp_t e;
      model_mask = model_mask | (8'h01 << {x, y, z});
      e.fq   = tbl[{x, y, z}];
      e.mask = model_mask;
      sb_q.push_back(e);
    end
  end

  // Reset clears model state immediately, like the DUT.
  always @(negedge rst_n) begin
    sb_q.delete();
    model_mask = 8'h00;
    hold = '0;
  end

  // Monitor: away from the active edge, pop one expectation per strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, sb_q.size() > 0);
      if (sb_q.size() > 0) hold = sb_q.pop_front();
      chk("f_q", {f1_q, f2_q, f3_q}, hold.fq);
      chk("cov_mask", cov_mask, model_mask);
      chk("cov_full", cov_full, model_mask == 8'hFF);
    end
  end

  task automatic drive(input int code, input logic iv, input logic gg);
    logic [2:0] c;
    @(posedge clk);
    #1;
    c = code[2:0];
    {x, y, z} = c;
    in_valid = iv;
    g = gg;
    #1;
    chk("comb", {f1, f2, f3}, tbl[c]);
  endtask

  initial begin
    rst_n = 1'b0; x = 0; y = 0; z = 0; g = 0; in_valid = 0;
    #3;
    chk("rst_fq", {f1_q, f2_q, f3_q}, 3'b000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_mask", cov_mask, 8'h00);
    chk("rst_full", cov_full, 1'b0);
    // Combinational sweep while held in reset.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] c;
      c = i[2:0];
      {x, y, z} = c;
      #1;
      chk("sweep", {f1, f2, f3}, tbl[c]);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Codes 0..7 back to back, then a frozen sample of code 6.
    for (int i = 0; i < 8; i++) drive(i, 1'b1, 1'b0);
    drive(6, 1'b1, 1'b1);
    drive(6, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_after_sweep", cov_full, 1'b1);

    // Fresh reset, then codes 2,2,4.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(2, 1'b1, 1'b0);
    drive(2, 1'b1, 1'b0);
    drive(4, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mask_224", cov_mask, 8'h14);

    // Codes 0..3, then asynchronous reset between edges.
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_fq", {f1_q, f2_q, f3_q}, 3'b000);
    chk("async_valid", out_valid, 1'b0);
    chk("async_mask", cov_mask, 8'h00);
    chk("async_full", cov_full, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Accept code 7, then idle for five cycles.
    drive(7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive($urandom_range(0, 7), 1'b0, $urandom_range(0, 1));
    @(negedge clk);
    #1;
    chk("hold7", {f1_q, f2_q, f3_q}, 3'b101);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    drive(0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
